mem_bus_arbiter: RTL and testbench

- Shares the single wishbone-style memory master port between the instruction-fetch requester and the data (load/store) requester.
- Sequences each bus transaction: grant, one-cycle strobe, wait for completion, one-cycle acknowledge.
- Data requests have priority; a bounded streak counter prevents instruction-fetch starvation.
- A watchdog counter terminates hung transactions with an error flag.

---
 rtl/mem_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for the shared wishbone-style memory master port.
// Data requests win unless fetch has waited MAX_D_STREAK grants; a watchdog ends hung transfers.
module mem_bus_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned TIMEOUT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_sel,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,

  output logic        read_i,
  output logic        write_i,
  output logic [31:0] adr_i,
  output logic [31:0] cpu_dat_i,
  output logic [3:0]  sel_i,
  input  logic        busy_o,
  input  logic [31:0] cpu_dat_o,

  output logic        arb_busy
);

  localparam int unsigned StreakW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;

  typedef enum logic [1:0] {StIdle, StArm, StWait, StResp} state_e;

  state_e               state_q;
  logic                 gnt_d_q;
  logic                 we_q;
  logic [StreakW-1:0]   streak_q;
  logic [TIMEOUT_W-1:0] wdog_q;

  logic streak_full;
  logic pick_d;

  // Streak only grows while fetch is pending, so it never passes MAX_D_STREAK.
  always_comb begin
    streak_full = (streak_q == StreakW'(MAX_D_STREAK));
    pick_d      = d_req & (~i_req | ~streak_full);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      gnt_d_q   <= 1'b0;
      we_q      <= 1'b0;
      streak_q  <= '0;
      wdog_q    <= '0;
      i_ack     <= 1'b0;
      i_rdata   <= '0;
      i_err     <= 1'b0;
      d_ack     <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
      read_i    <= 1'b0;
      write_i   <= 1'b0;
      adr_i     <= '0;
      cpu_dat_i <= '0;
      sel_i     <= '0;
      arb_busy  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_req | d_req) begin
            state_q  <= StArm;
            arb_busy <= 1'b1;
            gnt_d_q  <= pick_d;
            if (pick_d) begin
              we_q      <= d_we;
              adr_i     <= d_addr;
              sel_i     <= d_sel;
              cpu_dat_i <= d_we ? d_wdata : '0;
              read_i    <= ~d_we;
              write_i   <= d_we;
              streak_q  <= i_req ? streak_q + StreakW'(1) : '0;
            end else begin
              we_q      <= 1'b0;
              adr_i     <= i_addr;
              sel_i     <= 4'hF;
              cpu_dat_i <= '0;
              read_i    <= 1'b1;
              write_i   <= 1'b0;
              streak_q  <= '0;
            end
          end
        end

        StArm: begin
          read_i  <= 1'b0;
          write_i <= 1'b0;
          wdog_q  <= '0;
          state_q <= StWait;
        end

        StWait: begin
          if (!busy_o) begin
            state_q <= StResp;
            if (gnt_d_q) begin
              d_ack   <= 1'b1;
              d_rdata <= we_q ? '0 : cpu_dat_o;
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= cpu_dat_o;
            end
          end else if (wdog_q == TIMEOUT_W'(TIMEOUT)) begin
            // Hung slave: complete with an error and no data.
            state_q <= StResp;
            if (gnt_d_q) begin
              d_ack   <= 1'b1;
              d_err   <= 1'b1;
              d_rdata <= '0;
            end else begin
              i_ack   <= 1'b1;
              i_err   <= 1'b1;
              i_rdata <= '0;
            end
          end else begin
            wdog_q <= wdog_q + TIMEOUT_W'(1);
          end
        end

        StResp: begin
          state_q   <= StIdle;
          arb_busy  <= 1'b0;
          i_ack     <= 1'b0;
          i_err     <= 1'b0;
          i_rdata   <= '0;
          d_ack     <= 1'b0;
          d_err     <= 1'b0;
          d_rdata   <= '0;
          adr_i     <= '0;
          sel_i     <= '0;
          cpu_dat_i <= '0;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  // Only one requester owns the bus, so its ack and strobe are exclusive.
  assert property (@(posedge clk) !(i_ack && d_ack));
  assert property (@(posedge clk) !(read_i && write_i));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of grant priority, bus fields, latency, data and errors.
module tb_mem_bus_arbiter;

  localparam int unsigned MaxDStreak = 4;
  localparam int unsigned Timeout    = 255;
  localparam int unsigned TimeoutW   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req, i_ack, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ack, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_sel;
  logic        read_i, write_i, busy_o, arb_busy;
  logic [31:0] adr_i, cpu_dat_i, cpu_dat_o;
  logic [3:0]  sel_i;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned streak = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .MAX_D_STREAK(MaxDStreak),
    .TIMEOUT     (Timeout),
    .TIMEOUT_W   (TimeoutW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_ack    (i_ack),
    .i_rdata  (i_rdata),
    .i_err    (i_err),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_sel    (d_sel),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .d_err    (d_err),
    .read_i   (read_i),
    .write_i  (write_i),
    .adr_i    (adr_i),
    .cpu_dat_i(cpu_dat_i),
    .sel_i    (sel_i),
    .busy_o   (busy_o),
    .cpu_dat_o(cpu_dat_o),
    .arb_busy (arb_busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic rand_i();
    i_addr = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic rand_d();
    d_we    = 1'($urandom_range(0, 1));
    d_addr  = $urandom | 32'h4;
    d_wdata = $urandom;
    d_sel   = 4'($urandom_range(1, 15));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_flags"}, {i_ack, d_ack, i_err, d_err, read_i, write_i, arb_busy}, 64'h0);
    check_eq({tag, "_bus"}, {adr_i, cpu_dat_i}, 64'h0);
    check_eq({tag, "_sel"}, {60'h0, sel_i}, 64'h0);
    check_eq({tag, "_rdata"}, {i_rdata, d_rdata}, 64'h0);
  endtask

  // One cycle in IDLE after a response: acks, errors, data and address are gone.
  task automatic idle_check();
    @(negedge clk);
    check_eq("idle_flags", {i_ack, d_ack, i_err, d_err, read_i, write_i, arb_busy}, 64'h0);
    check_eq("idle_adr", adr_i, 64'h0);
    check_eq("idle_rdata", {i_rdata, d_rdata}, 64'h0);
  endtask

  // Called at a negedge in IDLE with requests already driven. Model predicts the winner,
  // bus fields, completion cycle, data and error; the bench plays the bus slave.
  task automatic do_grant(input int wait_len, input bit tmo, input bit late,
                          input bit fixed, input logic [31:0] fixed_val, output bit got_d);
    bit          gd, e_wr;
    logic [31:0] e_adr, e_dat, e_rd;
    logic [3:0]  e_sel;
    int          exp_n;

    gd = d_req && (!i_req || streak < MaxDStreak);
    if (gd) streak = i_req ? streak + 1 : 0;
    else    streak = 0;
    if (gd) begin
      e_wr = d_we; e_adr = d_addr; e_sel = d_sel; e_dat = d_we ? d_wdata : 32'h0;
    end else begin
      e_wr = 1'b0; e_adr = i_addr; e_sel = 4'hF; e_dat = 32'h0;
    end
    exp_n = tmo ? int'(Timeout) + 2 : wait_len + 2;
    e_rd  = 32'h0;

    @(negedge clk);
    check_eq("strobe", {read_i, write_i}, {!e_wr, e_wr});
    check_eq("arm_adr", adr_i, e_adr);
    check_eq("arm_sel", sel_i, e_sel);
    check_eq("arm_wdata", cpu_dat_i, e_dat);
    check_eq("arm_busy", {arb_busy, i_ack, d_ack}, 3'b100);
    busy_o    = tmo || (wait_len > 0);
    cpu_dat_o = fixed ? fixed_val : $urandom;

    for (int n = 1; n < exp_n; n++) begin
      @(negedge clk);
      check_eq("wait_quiet", {read_i, write_i, i_ack, d_ack, arb_busy}, 5'b00001);
      check_eq("adr_hold", adr_i, e_adr);
      if (late && n == 1) begin
        if (gd) d_addr = d_addr << 1;
        else    i_addr = i_addr << 1;
      end
      busy_o    = tmo || (n <= wait_len);
      cpu_dat_o = fixed ? fixed_val : $urandom;
      if (!tmo && n == wait_len + 1 && !(gd && e_wr)) e_rd = cpu_dat_o;
    end

    @(negedge clk);
    check_eq("ack", {i_ack, d_ack}, {!gd, gd});
    check_eq("err", {i_err, d_err}, {!gd && tmo, gd && tmo});
    check_eq("rdata", gd ? d_rdata : i_rdata, e_rd);
    check_eq("other_rdata", gd ? i_rdata : d_rdata, 32'h0);
    check_eq("resp_adr", adr_i, e_adr);
    check_eq("resp_quiet", {read_i, write_i, arb_busy}, 3'b001);
    busy_o = 1'b0;
    got_d  = d_ack;
  endtask

  initial begin
    bit         g;
    logic [9:0] obs;

    i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0;
    d_wdata = 32'h0; d_sel = 4'h0; busy_o = 1'b0; cpu_dat_o = 32'h0;

    // Reset holds everything at zero even with requests pending.
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check_all_zero("reset2");

    // Fetch only.
    rst = 1'b1; i_req = 1'b1; i_addr = 32'h100;
    do_grant(0, 1'b0, 1'b0, 1'b1, 32'h0050_0093, g);
    check_eq("fetch_winner", g, 1'b0);
    i_req = 1'b0;
    idle_check();

    // Store with five busy cycles.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_sel = 4'h3;
    do_grant(5, 1'b0, 1'b0, 1'b0, 32'h0, g);
    check_eq("store_winner", g, 1'b1);
    d_req = 1'b0;
    idle_check();

    // Contention with both requests held continuously.
    rand_i(); rand_d(); i_req = 1'b1; d_req = 1'b1; obs = '0;
    for (int k = 0; k < 10; k++) begin
      do_grant($urandom_range(0, 3), 1'b0, 1'b0, 1'b0, 32'h0, g);
      obs = {obs[8:0], g};
      if (k == 9) begin
        i_req = 1'b0; d_req = 1'b0;
      end else if (g) begin
        rand_d();
      end else begin
        rand_i();
      end
      idle_check();
    end
    check_eq("contention_order", obs, 10'b11110_11110);

    // Load against a stuck slave.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_sel = 4'hF;
    do_grant(0, 1'b1, 1'b0, 1'b0, 32'h0, g);
    d_req = 1'b0;
    idle_check();

    // Requester address changes during WAIT.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_sel = 4'hF;
    do_grant(3, 1'b0, 1'b1, 1'b0, 32'h0, g);
    d_req = 1'b0;
    idle_check();

    // Reset during WAIT abandons the fetch; a fresh fetch then completes.
    i_req = 1'b1; rand_i();
    @(negedge clk);
    check_eq("rst_arm", {read_i, write_i}, 2'b10);
    busy_o = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("rst_mid");
    rst = 1'b1; busy_o = 1'b0; rand_i(); streak = 0;
    do_grant(1, 1'b0, 1'b0, 1'b0, 32'h0, g);
    i_req = 1'b0;
    idle_check();

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      if (!i_req && !d_req) begin
        repeat ($urandom_range(0, 2)) idle_check();
        case ($urandom_range(0, 2))
          0:       begin i_req = 1'b1; rand_i(); end
          1:       begin d_req = 1'b1; rand_d(); end
          default: begin i_req = 1'b1; d_req = 1'b1; rand_i(); rand_d(); end
        endcase
      end
      do_grant($urandom_range(0, 6), $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
               1'b0, 32'h0, g);
      if (g) begin
        d_req = 1'($urandom_range(0, 1));
        rand_d();
        if (!i_req && $urandom_range(0, 3) == 0) begin i_req = 1'b1; rand_i(); end
      end else begin
        i_req = 1'($urandom_range(0, 1));
        rand_i();
        if (!d_req && $urandom_range(0, 3) == 0) begin d_req = 1'b1; rand_d(); end
      end
      idle_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
